// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared ALU opcodes and multiply sequencer state encoding
package mips_alu_pkg;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_NOR = 5'b01100;

   localparam int unsigned MULT_WIDTH = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NEG_A,
      ST_NEG_B,
      ST_ITER,
      ST_NEG_LO,
      ST_NEG_HI,
      ST_DONE
   } mult_state_t;

endpackage

// File: rtl/mult_seq_if.sv
// rtl/mult_seq_if.sv - request/response handshake between the execute stage and mult_seq
interface mult_seq_if;
   import mips_alu_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [MULT_WIDTH-1:0] in_a;
   logic [MULT_WIDTH-1:0] in_b;
   logic                  in_signed;
   logic                  out_valid;
   logic                  out_ready;
   logic [MULT_WIDTH-1:0] out_hi;
   logic [MULT_WIDTH-1:0] out_lo;

   modport master (
      output in_valid, in_a, in_b, in_signed, out_ready,
      input  in_ready, out_valid, out_hi, out_lo
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, out_ready,
      output in_ready, out_valid, out_hi, out_lo
   );

endinterface

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - iterative 32x32->64 shift-add multiplier driving the shared ALU
// MULT_SEQ_SIGNED_EN adds sign-magnitude pre/post negation states for MULT.
module mult_seq
   import mips_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   mult_seq_if.slave   bus,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_x,
   output logic [31:0] alu_y,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_res,
   input  logic        alu_c_out,
   input  logic        alu_zero
);

   mult_state_t state;
   logic [31:0] mcand;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [4:0]  cnt;
`ifdef MULT_SEQ_SIGNED_EN
   logic        neg;
   logic        lo_zero;
   logic        is_signed;
`else
   logic        unused_inputs;
   assign unused_inputs = ^{bus.in_signed, alu_zero};
`endif

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.out_hi    = hi;
   assign bus.out_lo    = lo;
   assign alu_shamt     = 5'd0;

   always_comb begin
      alu_op = ALU_ADD;
      alu_x  = '0;
      alu_y  = '0;
      case (state)
         ST_ITER: begin
            alu_x = hi;
            alu_y = lo[0] ? mcand : '0;
         end
`ifdef MULT_SEQ_SIGNED_EN
         ST_NEG_A: begin
            alu_op = ALU_SUB;
            alu_y  = mcand;
         end
         ST_NEG_B, ST_NEG_LO: begin
            alu_op = ALU_SUB;
            alu_y  = lo;
         end
         ST_NEG_HI: begin
            // A zero low word means the +1 of the two's complement carries into hi.
            if (lo_zero) begin
               alu_op = ALU_SUB;
               alu_y  = hi;
            end else begin
               alu_op = ALU_NOR;
               alu_x  = hi;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mcand     <= '0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
`ifdef MULT_SEQ_SIGNED_EN
         neg       <= 1'b0;
         lo_zero   <= 1'b0;
         is_signed <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  mcand <= bus.in_a;
                  lo    <= bus.in_b;
                  hi    <= '0;
                  cnt   <= 5'd31;
`ifdef MULT_SEQ_SIGNED_EN
                  is_signed <= bus.in_signed;
                  neg       <= bus.in_signed & (bus.in_a[31] ^ bus.in_b[31]);
                  state     <= bus.in_signed ? ST_NEG_A : ST_ITER;
`else
                  state <= ST_ITER;
`endif
               end
            end
            ST_ITER: begin
               hi  <= {alu_c_out, alu_res[31:1]};
               lo  <= {alu_res[0], lo[31:1]};
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0) begin
`ifdef MULT_SEQ_SIGNED_EN
                  state <= is_signed ? ST_NEG_LO : ST_DONE;
`else
                  state <= ST_DONE;
`endif
               end
            end
`ifdef MULT_SEQ_SIGNED_EN
            ST_NEG_A: begin
               if (mcand[31]) mcand <= alu_res;
               state <= ST_NEG_B;
            end
            ST_NEG_B: begin
               if (lo[31]) lo <= alu_res;
               state <= ST_ITER;
            end
            ST_NEG_LO: begin
               if (neg) lo <= alu_res;
               lo_zero <= alu_zero;
               state   <= ST_NEG_HI;
            end
            ST_NEG_HI: begin
               if (neg) hi <= alu_res;
               state <= ST_DONE;
            end
`endif
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - directed-vector bench for mult_seq with a behavioural ALU
module tb_mult_seq;

   logic        clk;
   logic        rst_n;
   logic [4:0]  alu_op;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_res;
   logic        alu_c_out;
   logic        alu_zero;
   logic [32:0] alu_sum;

   int checks;
   int failures;

   mult_seq_if bus ();

   mult_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .alu_op    (alu_op),
      .alu_x     (alu_x),
      .alu_y     (alu_y),
      .alu_shamt (alu_shamt),
      .alu_res   (alu_res),
      .alu_c_out (alu_c_out),
      .alu_zero  (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      alu_sum = '0;
      case (alu_op)
         5'b00000: alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
         5'b00001: alu_sum = {1'b0, alu_x} - {1'b0, alu_y};
         5'b01100: alu_sum = {1'b0, ~(alu_x | alu_y)};
         default:  alu_sum = '0;
      endcase
   end
   assign alu_res   = alu_sum[31:0];
   assign alu_c_out = alu_sum[32];
   assign alu_zero  = (alu_sum[31:0] == 32'd0);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Edge count includes the accept edge itself.
   task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input int exp_lat, input int hold);
      int edges;
      @(negedge clk);
      check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_signed = s;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a     = 32'hDEAD_BEEF;
      bus.in_b     = 32'hDEAD_BEEF;
      edges = 1;
      while (!bus.out_valid && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
      check_eq({tag, "_latency"}, 64'(edges), 64'(exp_lat));
      check_eq({tag, "_product"}, {bus.out_hi, bus.out_lo}, {exp_hi, exp_lo});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_eq({tag, "_bp_hold"}, {bus.out_valid, bus.in_ready, bus.out_hi, bus.out_lo},
                  {1'b1, 1'b0, exp_hi, exp_lo});
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq({tag, "_to_idle"}, {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_signed = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check_eq("rst_handshake", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
      check_eq("rst_product", {bus.out_hi, bus.out_lo}, 64'd0);
      check_eq("rst_alu", {27'd0, alu_op, alu_shamt, alu_x, alu_y}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_mult("multu_3x5", 32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F, 33, 0);
      run_mult("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
`ifdef MULT_SEQ_SIGNED_EN
      run_mult("mult_m2x3", 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 37, 0);
      run_mult("mult_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 37, 0);
      run_mult("mult_lozero", 32'hFFFF_0000, 32'h0001_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 37, 0);
      run_mult("mult_pos", 32'd1000, 32'd2000, 1'b1, 32'h0000_0000, 32'd2000000, 37, 0);
`else
      run_mult("signed_ignored", 32'hFFFF_FFFE, 32'd3, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA, 33, 0);
`endif
      run_mult("backpressure", 32'h1234_5678, 32'h0000_0100, 1'b0, 32'h0000_0012, 32'h3456_7800, 33, 10);
      run_mult("after_bp", 32'd10, 32'd10, 1'b0, 32'h0000_0000, 32'd100, 33, 0);

      // Abort a request once ITER has counted down to 15.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = 32'hFFFF_FFFF;
      bus.in_b      = 32'hFFFF_FFFF;
      bus.in_signed = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("abort_handshake", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 1'b1, 1'b0});
      check_eq("abort_product", {bus.out_hi, bus.out_lo}, 64'd0);
      check_eq("abort_alu", {27'd0, alu_op, alu_shamt, alu_x, alu_y}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check_eq("abort_no_valid", 64'(bus.out_valid), 64'd0);
      end
      run_mult("post_abort_7x6", 32'd7, 32'd6, 1'b0, 32'h0000_0000, 32'd42, 33, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
